// File: rtl/timer_counter_cmp.sv
// ----------------------------------------------------------------------------
// timer_counter_cmp
//   64-bit main timer counter with a 64-bit compare register and a sticky
//   interrupt status. The counter advances once per cycle while cnt_en is
//   high. Software can write either 32-bit half of the count or the compare
//   value. A 1->0 transition of timer_en clears the counter.
//
// Ports
//   sys_clk     in   1   system clock, rising edge
//   sys_rst     in   1   synchronous, active-high reset
//   cnt_en      in   1   count qualifier (one increment per high cycle)
//   timer_en    in   1   timer enable; falling edge clears the counter
//   wdata       in   32  software write data
//   cnt_wr_lo   in   1   load wdata into cnt_val[31:0]
//   cnt_wr_hi   in   1   load wdata into cnt_val[63:32]
//   cmp_wr_lo   in   1   load wdata into cmp_val[31:0]
//   cmp_wr_hi   in   1   load wdata into cmp_val[63:32]
//   int_en      in   1   interrupt output enable
//   int_st_clr  in   1   write-1-to-clear pulse for int_st
//   cnt_val     out  64  current count
//   cmp_val     out  64  current compare value
//   int_st      out  1   sticky interrupt status
//   tim_int     out  1   interrupt output (int_st gated by int_en)
// ----------------------------------------------------------------------------
module timer_counter_cmp #(
    parameter logic [63:0] CNT_RST = 64'h0,
    parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cnt_en,
    input  logic        timer_en,
    input  logic [31:0] wdata,
    input  logic        cnt_wr_lo,
    input  logic        cnt_wr_hi,
    input  logic        cmp_wr_lo,
    input  logic        cmp_wr_hi,
    input  logic        int_en,
    input  logic        int_st_clr,
    output logic [63:0] cnt_val,
    output logic [63:0] cmp_val,
    output logic        int_st,
    output logic        tim_int
);

    logic timer_en_d;
    logic en_fall;
    logic match;

    assign en_fall = timer_en_d & ~timer_en;

    // Level compare on registered values: int_st follows one cycle later.
    assign match = (cnt_val == cmp_val);

    // Masking is combinational so toggling int_en never disturbs int_st.
    assign tim_int = int_st & int_en;

    // NOTE: sys_rst is sampled only on the clock edge, so it sits inside the
    // clocked block instead of the sensitivity list.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            // NOTE: sequential state always uses <= so every register samples
            // the pre-edge values regardless of statement order.
            cnt_val    <= CNT_RST;
            cmp_val    <= CMP_RST;
            int_st     <= 1'b0;
            timer_en_d <= 1'b0;
        end else begin
            timer_en_d <= timer_en;

            // Software writes win over the enable-fall clear and the
            // increment; an unwritten half simply holds.
            if (cnt_wr_lo || cnt_wr_hi) begin
                if (cnt_wr_lo) cnt_val[31:0]  <= wdata;
                if (cnt_wr_hi) cnt_val[63:32] <= wdata;
            end else if (en_fall) begin
                cnt_val <= CNT_RST;
            end else if (cnt_en) begin
                cnt_val <= cnt_val + 64'd1;   // wraps silently at all-ones
            end

            if (cmp_wr_lo) cmp_val[31:0]  <= wdata;
            if (cmp_wr_hi) cmp_val[63:32] <= wdata;

            // Set beats clear, so a held match keeps re-asserting the status.
            if (match) begin
                int_st <= 1'b1;
            end else if (int_st_clr) begin
                int_st <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timer_counter_cmp.sv
// ----------------------------------------------------------------------------
// tb_timer_counter_cmp
//   Directed bench for timer_counter_cmp. Inputs are driven 1 ns after the
//   rising edge and outputs are sampled at the same point, so each tick()
//   represents exactly one clock edge of progress.
// ----------------------------------------------------------------------------
module tb_timer_counter_cmp;

    logic        sys_clk;
    logic        sys_rst;
    logic        cnt_en;
    logic        timer_en;
    logic [31:0] wdata;
    logic        cnt_wr_lo;
    logic        cnt_wr_hi;
    logic        cmp_wr_lo;
    logic        cmp_wr_hi;
    logic        int_en;
    logic        int_st_clr;
    logic [63:0] cnt_val;
    logic [63:0] cmp_val;
    logic        int_st;
    logic        tim_int;

    int n_checks = 0;
    int n_fail   = 0;

    timer_counter_cmp dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cnt_en     (cnt_en),
        .timer_en   (timer_en),
        .wdata      (wdata),
        .cnt_wr_lo  (cnt_wr_lo),
        .cnt_wr_hi  (cnt_wr_hi),
        .cmp_wr_lo  (cmp_wr_lo),
        .cmp_wr_hi  (cmp_wr_hi),
        .int_en     (int_en),
        .int_st_clr (int_st_clr),
        .cnt_val    (cnt_val),
        .cmp_val    (cmp_val),
        .int_st     (int_st),
        .tim_int    (tim_int)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst    = 1'b1;
        cnt_en     = 1'b0;
        timer_en   = 1'b0;
        wdata      = 32'h0;
        cnt_wr_lo  = 1'b0;
        cnt_wr_hi  = 1'b0;
        cmp_wr_lo  = 1'b0;
        cmp_wr_hi  = 1'b0;
        int_en     = 1'b0;
        int_st_clr = 1'b0;
        tick();
        sys_rst = 1'b0;
        n_checks++;
        if (cnt_val !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h expected %h", cnt_val, 64'h0);
        end
        n_checks++;
        if (cmp_val !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL reset_cmp: got %h expected %h", cmp_val, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        n_checks++;
        if (int_st !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_int_st: got %b expected 0", int_st);
        end
        n_checks++;
        if (tim_int !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tim_int: got %b expected 0", tim_int);
        end
    endtask

    task automatic test_count();
        timer_en = 1'b1;
        cnt_en   = 1'b1;
        repeat (5) tick();
        cnt_en = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (cnt_val !== 64'd5) begin
            n_fail++;
            $display("FAIL count_5: got %0d expected 5", cnt_val);
        end
        // Enable fall clears, then count with a 1/0 qualifier pattern.
        timer_en = 1'b0;
        tick();
        n_checks++;
        if (cnt_val !== 64'd0) begin
            n_fail++;
            $display("FAIL count_clear: got %0d expected 0", cnt_val);
        end
        timer_en = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            cnt_en = (i % 2 == 0);
            tick();
        end
        cnt_en = 1'b0;
        tick();
        n_checks++;
        if (cnt_val !== 64'd5) begin
            n_fail++;
            $display("FAIL count_alt: got %0d expected 5", cnt_val);
        end
    endtask

    task automatic test_carry_wrap();
        wdata     = 32'hFFFF_FFFF;
        cnt_wr_lo = 1'b1;
        tick();
        cnt_wr_lo = 1'b0;
        wdata     = 32'h0;
        cnt_wr_hi = 1'b1;
        tick();
        cnt_wr_hi = 1'b0;
        n_checks++;
        if (cnt_val !== 64'h0000_0000_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL carry_load: got %h expected %h", cnt_val, 64'h0000_0000_FFFF_FFFF);
        end
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
        n_checks++;
        if (cnt_val !== 64'h0000_0001_0000_0000) begin
            n_fail++;
            $display("FAIL carry_32: got %h expected %h", cnt_val, 64'h0000_0001_0000_0000);
        end
        // Both halves in one cycle; all-ones also equals the reset compare.
        wdata     = 32'hFFFF_FFFF;
        cnt_wr_lo = 1'b1;
        cnt_wr_hi = 1'b1;
        tick();
        cnt_wr_lo = 1'b0;
        cnt_wr_hi = 1'b0;
        n_checks++;
        if (cnt_val !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_load: got %h expected all-ones", cnt_val);
        end
        n_checks++;
        if (int_st !== 1'b0) begin
            n_fail++;
            $display("FAIL match_latency: got %b expected 0", int_st);
        end
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
        n_checks++;
        if (cnt_val !== 64'h0) begin
            n_fail++;
            $display("FAIL wrap_zero: got %h expected 0", cnt_val);
        end
        // Count write reached the compare value in the previous cycle.
        n_checks++;
        if (int_st !== 1'b1) begin
            n_fail++;
            $display("FAIL write_match_set: got %b expected 1", int_st);
        end
        n_checks++;
        if (tim_int !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_after_wrap: got %b expected 0", tim_int);
        end
    endtask

    task automatic test_write_vs_count();
        wdata     = 32'h10;
        cnt_wr_lo = 1'b1;
        cnt_en    = 1'b1;
        tick();
        cnt_wr_lo = 1'b0;
        cnt_en    = 1'b0;
        n_checks++;
        if (cnt_val !== 64'd16) begin
            n_fail++;
            $display("FAIL write_priority: got %0d expected 16", cnt_val);
        end
        timer_en = 1'b0;
        tick();
        n_checks++;
        if (cnt_val !== 64'd0) begin
            n_fail++;
            $display("FAIL en_fall_clear: got %0d expected 0", cnt_val);
        end
        timer_en = 1'b1;
        tick();
    endtask

    task automatic test_compare();
        wdata     = 32'd3;
        cmp_wr_lo = 1'b1;
        tick();
        cmp_wr_lo = 1'b0;
        wdata     = 32'd0;
        cmp_wr_hi = 1'b1;
        tick();
        cmp_wr_hi = 1'b0;
        n_checks++;
        if (cmp_val !== 64'd3) begin
            n_fail++;
            $display("FAIL cmp_load: got %h expected 3", cmp_val);
        end
        int_st_clr = 1'b1;
        tick();
        int_st_clr = 1'b0;
        n_checks++;
        if (int_st !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_no_match: got %b expected 0", int_st);
        end
        int_en = 1'b1;
        cnt_en = 1'b1;
        repeat (3) tick();
        cnt_en = 1'b0;
        n_checks++;
        if (cnt_val !== 64'd3 || int_st !== 1'b0) begin
            n_fail++;
            $display("FAIL reach_cmp: got cnt=%0d int_st=%b expected cnt=3 int_st=0", cnt_val, int_st);
        end
        tick();
        n_checks++;
        if (int_st !== 1'b1 || tim_int !== 1'b1) begin
            n_fail++;
            $display("FAIL match_set: got int_st=%b tim_int=%b expected 1 1", int_st, tim_int);
        end
        int_st_clr = 1'b1;
        tick();
        int_st_clr = 1'b0;
        n_checks++;
        if (int_st !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_clr: got %b expected 1", int_st);
        end
        cnt_en = 1'b1;
        tick();
        cnt_en     = 1'b0;
        int_st_clr = 1'b1;
        tick();
        int_st_clr = 1'b0;
        n_checks++;
        if (cnt_val !== 64'd4 || int_st !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_after_pass: got cnt=%0d int_st=%b expected cnt=4 int_st=0", cnt_val, int_st);
        end
    endtask

    task automatic test_masking();
        wdata     = 32'd3;
        cnt_wr_lo = 1'b1;
        tick();
        cnt_wr_lo = 1'b0;
        tick();
        n_checks++;
        if (int_st !== 1'b1 || tim_int !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_setup: got int_st=%b tim_int=%b expected 1 1", int_st, tim_int);
        end
        int_en = 1'b0;
        #1;
        n_checks++;
        if (tim_int !== 1'b0 || int_st !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_off: got tim_int=%b int_st=%b expected 0 1", tim_int, int_st);
        end
        int_en = 1'b1;
        #1;
        n_checks++;
        if (tim_int !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_on: got %b expected 1", tim_int);
        end
    endtask

    task automatic test_reset_override();
        sys_rst   = 1'b1;
        cnt_en    = 1'b1;
        wdata     = 32'h1234_5678;
        cnt_wr_lo = 1'b1;
        cmp_wr_hi = 1'b1;
        tick();
        sys_rst   = 1'b0;
        cnt_en    = 1'b0;
        cnt_wr_lo = 1'b0;
        cmp_wr_hi = 1'b0;
        n_checks++;
        if (cnt_val !== 64'h0 || cmp_val !== 64'hFFFF_FFFF_FFFF_FFFF || int_st !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_override: got cnt=%h cmp=%h int_st=%b expected 0 all-ones 0",
                     cnt_val, cmp_val, int_st);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_carry_wrap();
        test_write_vs_count();
        test_compare();
        test_masking();
        test_reset_override();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
